can_tx_scheduler: RTL

- Transmit scheduler that shares the single CAN transmit path (the bit-stuffing tx container) between NUM_MB mailboxes.
- Picks the pending mailbox with the highest CAN priority (lowest 11-bit ID) and presents its ID and payload to the transmitter.
- Drives `send_data`, tracks `txing` to completion, and reports per-mailbox done/error pulses.
- Sits between the host-side mailbox registers and the transmitter.

---
 rtl/can_tx_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/can_tx_scheduler.sv
// Shares one CAN transmitter between NUM_MB mailboxes: lowest-ID arbitration,
// start timeout with bounded retries, and enforced inter-frame spacing.
module can_tx_scheduler #(
    parameter int unsigned NUM_MB     = 4,
    parameter logic [15:0] START_TO   = 16'd4000,
    parameter int unsigned MAX_RETRY  = 3,
    parameter logic [15:0] IFS_CYCLES = 16'd600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_MB-1:0]    req,
    input  logic [NUM_MB*11-1:0] mb_addr,
    input  logic [NUM_MB*64-1:0] mb_data,
    input  logic                 txing,
    output logic [10:0]          address,
    output logic [63:0]          data,
    output logic                 send_data,
    output logic [2:0]           grant,
    output logic                 busy,
    output logic [NUM_MB-1:0]    done,
    output logic [NUM_MB-1:0]    err
);

    localparam int unsigned IW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RETRY,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_sel;
    logic [10:0]       r_address;
    logic [63:0]       r_data;
    logic              r_send;
    logic              r_busy;
    logic [NUM_MB-1:0] r_done;
    logic [NUM_MB-1:0] r_err;
    logic [15:0]       r_timer;
    logic [RW-1:0]     r_retry;
    logic [NUM_MB-1:0] r_blocked;

    logic [NUM_MB-1:0] w_cand;
    logic [NUM_MB-1:0] w_sel_oh;
    logic              w_found;
    logic [IW-1:0]     w_idx;
    logic [10:0]       w_addr;
    logic [63:0]       w_data;

    assign w_cand   = req & ~r_blocked;
    assign w_sel_oh = {{(NUM_MB-1){1'b0}}, 1'b1} << r_sel;

    // Lowest ID wins; strict compare keeps the lowest index on ties.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_addr  = '0;
        w_data  = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (w_cand[i] && (!w_found || (mb_addr[11*i +: 11] < w_addr))) begin
                w_found = 1'b1;
                w_idx   = IW'(i);
                w_addr  = mb_addr[11*i +: 11];
                w_data  = mb_data[64*i +: 64];
            end
        end
    end

    // r_timer times the start window, the retry pause and the inter-frame gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_send    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= '0;
            r_err     <= '0;
            r_timer   <= '0;
            r_retry   <= '0;
            r_blocked <= '0;
        end else begin
            r_done    <= '0;
            r_err     <= '0;
            r_blocked <= r_blocked & req;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel     <= w_idx;
                        r_address <= w_addr;
                        r_data    <= w_data;
                        r_send    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_timer   <= '0;
                        r_retry   <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (txing) begin
                        r_send  <= 1'b0;
                        r_state <= S_ACTIVE;
                    end else if (!req[r_sel]) begin
                        r_send  <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_GAP;
                    end else if (r_timer == START_TO - 16'd1) begin
                        r_send  <= 1'b0;
                        r_timer <= '0;
                        if (r_retry < RETRY_LIM) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_RETRY;
                        end else begin
                            r_err     <= w_sel_oh;
                            r_blocked <= (r_blocked & req) | w_sel_oh;
                            r_state   <= S_GAP;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_RETRY: begin
                    if (r_timer == 16'd1) begin
                        r_timer <= '0;
                        r_send  <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_ACTIVE: begin
                    if (!txing) begin
                        r_done  <= w_sel_oh;
                        r_timer <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_timer == IFS_CYCLES - 16'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign address   = r_address;
    assign data      = r_data;
    assign send_data = r_send;
    assign grant     = 3'(r_sel);
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
